// File: rtl/fb_arbiter.sv
// Frame-buffer arbiter: one single-port RAM shared between display reads (absolute priority) and buffered writer commits.
// Optional macro FB_WR_FIFO_EN selects a 4-entry write FIFO instead of the single holding register.
module fb_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              wr_pending,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t              r_state;
  logic                r_ram_en;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic                r_rd_vld_p1;
  logic                r_disp_vld_p2;
  logic [DATA_W-1:0]   r_disp_data_p2;
  logic [15:0]         r_stall_cnt;

  logic                w_ready;
  logic                w_pending;
  logic                w_push;
  logic                w_pop;
  logic [ADDR_W-1:0]   w_head_addr;
  logic [DATA_W-1:0]   w_head_data;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_push = wr_valid && w_ready;
  // The head leaves the buffer on the same edge that loads it into the RAM port.
  assign w_pop  = !disp_req && w_pending;

`ifdef FB_WR_FIFO_EN
  localparam int DEPTH = 4;

  logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
  logic [DATA_W-1:0] r_fifo_data [DEPTH];
  logic [1:0]        r_wptr;
  logic [1:0]        r_rptr;
  logic [2:0]        r_count;

  assign w_ready     = (r_count != 3'd4);
  assign w_pending   = (r_count != 3'd0);
  assign w_head_addr = r_fifo_addr[r_rptr];
  assign w_head_data = r_fifo_data[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 2'd1;
      if (w_pop)  r_rptr <= r_rptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= wr_addr;
      r_fifo_data[r_wptr] <= wr_data;
    end
  end
`else
  logic              r_hold_vld;
  logic [ADDR_W-1:0] r_hold_addr;
  logic [DATA_W-1:0] r_hold_data;

  // Ready only while empty, so a pop and a refill never share an edge.
  assign w_ready     = !r_hold_vld;
  assign w_pending   = r_hold_vld;
  assign w_head_addr = r_hold_addr;
  assign w_head_data = r_hold_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_hold_vld <= 1'b0;
    else if (w_push) r_hold_vld <= 1'b1;
    else if (w_pop)  r_hold_vld <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_hold_addr <= wr_addr;
      r_hold_data <= wr_data;
    end
  end
`endif

  // p0: arbitration and RAM port registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else if (disp_req) begin
      r_state    <= RD;
      r_ram_en   <= 1'b1;
      r_ram_we   <= 1'b0;
      r_ram_addr <= disp_addr;
    end else if (w_pending) begin
      r_state     <= WR;
      r_ram_en    <= 1'b1;
      r_ram_we    <= 1'b1;
      r_ram_addr  <= w_head_addr;
      r_ram_wdata <= w_head_data;
    end else begin
      r_state  <= IDLE;
      r_ram_en <= 1'b0;
      r_ram_we <= 1'b0;
    end
  end

  // p1: RAM access in progress; p2: capture read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_vld_p1    <= 1'b0;
      r_disp_vld_p2  <= 1'b0;
      r_disp_data_p2 <= '0;
    end else begin
      r_rd_vld_p1    <= (r_state == RD);
      r_disp_vld_p2  <= r_rd_vld_p1;
      r_disp_data_p2 <= r_rd_vld_p1 ? ram_rdata : '0;
    end
  end

  // No assignment when idle, so the count is only ever touched by a real stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_stall_cnt <= '0;
    else if (disp_req && w_pending) r_stall_cnt <= sat_inc(r_stall_cnt);
  end

  assign ram_en     = r_ram_en;
  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign disp_valid = r_disp_vld_p2;
  assign disp_data  = r_disp_data_p2;
  assign wr_ready   = w_ready;
  assign wr_pending = w_pending;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_fb_arbiter.sv
// Scoreboard bench for fb_arbiter: stimulus queues expected display reads and RAM writes; a negedge monitor consumes them.
module tb_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        disp_req = 1'b0;
  logic [15:0] disp_addr = '0;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ready;
  logic        ram_en;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        wr_pending;
  logic [15:0] stall_cnt;

  fb_arbiter dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .wr_pending(wr_pending), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port RAM, 1-cycle read latency
  logic [7:0] mem [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'hA5;
    mem[16'h0030] = 8'h77;
    ram_rdata = 8'h00;
    forever begin
      @(posedge clk);
      if (ram_en) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else        ram_rdata <= mem[ram_addr];
      end
    end
  end

  typedef struct { logic [7:0] d; int c; } rd_t;
  typedef struct { logic [15:0] a; logic [7:0] d; int c; } wr_t;
  rd_t rq[$];
  wr_t wq[$];

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] exp_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (disp_valid) begin
      if (rq.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else begin
        rd_t e;
        e = rq.pop_front();
        chk("rd_data", {24'd0, disp_data}, {24'd0, e.d});
        chk("rd_cycle", cyc, e.c);
      end
    end else begin
      chk("rd_idle_zero", {24'd0, disp_data}, 32'd0);
    end
    if (ram_en && ram_we) begin
      if (wq.size() == 0) chk("wr_unexpected", {16'd0, ram_addr}, 32'hFFFF_FFFF);
      else begin
        wr_t w;
        w = wq.pop_front();
        chk("wr_addr", {16'd0, ram_addr}, {16'd0, w.a});
        chk("wr_data", {24'd0, ram_wdata}, {24'd0, w.d});
        if (w.c >= 0) chk("wr_cycle", cyc, w.c);
      end
    end
  end

  task automatic tick();
    if (disp_req) rq.push_back('{exp_rd, cyc + 3});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int lat);
    bit ok = 1'b0;
    wr_addr  = a;
    wr_data  = d;
    wr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (wr_ready) begin
        wq.push_back('{a, d, (lat < 0) ? -1 : cyc + lat});
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    wr_valid = 1'b0;
    chk("wr_accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic do_reset(input bit check);
    #2 rst = 1'b1;
    rq.delete();
    wq.delete();
    disp_req = 1'b0;
    wr_valid = 1'b0;
    #1;
    if (check) begin
      chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
      chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
      chk("rst_ram_addr", {16'd0, ram_addr}, 32'd0);
      chk("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
      chk("rst_disp_valid", {31'd0, disp_valid}, 32'd0);
      chk("rst_disp_data", {24'd0, disp_data}, 32'd0);
      chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      chk("rst_wr_pending", {31'd0, wr_pending}, 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int we_seen;
    // Power-on reset state
    #1;
    chk("init_ram_en", {31'd0, ram_en}, 32'd0);
    chk("init_ram_addr", {16'd0, ram_addr}, 32'd0);
    chk("init_disp_valid", {31'd0, disp_valid}, 32'd0);
    chk("init_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("init_wr_pending", {31'd0, wr_pending}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("init_wr_ready", {31'd0, wr_ready}, 32'd1);
    tick();

    // Single display read of 0x0010 -> A5 two edges after sampling
    disp_addr = 16'h0010; exp_rd = 8'hA5; disp_req = 1'b1;
    tick();
    disp_req = 1'b0;
    chk("rd_ram_en", {31'd0, ram_en}, 32'd1);
    chk("rd_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rd_ram_addr", {16'd0, ram_addr}, 32'h0010);
    tick();
    chk("rd_not_yet", {31'd0, disp_valid}, 32'd0);
    tick();
    chk("rd_valid_lat2", {31'd0, disp_valid}, 32'd1);
    repeat (3) tick();

    // Idle write then readback
    do_write(16'h0020, 8'h3C, 2);
    tick();
    chk("wr_ram_we", {31'd0, ram_we}, 32'd1);
    chk("wr_ram_addr", {16'd0, ram_addr}, 32'h0020);
    chk("wr_ram_wdata", {24'd0, ram_wdata}, 32'h3C);
    tick();
    disp_addr = 16'h0020; exp_rd = 8'h3C; disp_req = 1'b1;
    tick();
    disp_req = 1'b0;
    repeat (4) tick();

    // 100 stalled cycles; pending write to 0x0030 is not forwarded to reads
    do_reset(1'b0);
    disp_addr = 16'h0030; exp_rd = 8'h77; disp_req = 1'b1;
    do_write(16'h0030, 8'h11, -1);
    we_seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      we_seen += int'(ram_we);
    end
    chk("stall_no_we", we_seen, 32'd0);
    chk("stall_pending", {31'd0, wr_pending}, 32'd1);
    chk("stall_cnt_100", {16'd0, stall_cnt}, 32'd100);
    disp_req = 1'b0;
    if (wq.size() == 1) wq[0].c = cyc + 1;
    tick();
    tick();
    chk("stall_cnt_hold", {16'd0, stall_cnt}, 32'd100);
    disp_addr = 16'h0030; exp_rd = 8'h11; disp_req = 1'b1;
    tick();
    disp_req = 1'b0;
    repeat (4) tick();

    // Back-to-back writes against a busy display
    disp_addr = 16'h0010; exp_rd = 8'hA5; disp_req = 1'b1;
`ifdef FB_WR_FIFO_EN
    for (int i = 0; i < 4; i++) do_write(16'h0060 + 16'(i), 8'hB0 + 8'(i), -1);
    chk("fifo_full_ready", {31'd0, wr_ready}, 32'd0);
    wr_addr = 16'h0064; wr_data = 8'hB4; wr_valid = 1'b1;
    disp_req = 1'b0;
    tick();
    chk("fifo_ready_after_pop", {31'd0, wr_ready}, 32'd1);
    wq.push_back('{16'h0064, 8'hB4, -1});
    tick();
    wr_valid = 1'b0;
`else
    do_write(16'h0060, 8'hB0, -1);
    chk("hold_full_ready", {31'd0, wr_ready}, 32'd0);
    wr_addr = 16'h0061; wr_data = 8'hB1; wr_valid = 1'b1;
    disp_req = 1'b0;
    tick();
    chk("hold_ready_after_pop", {31'd0, wr_ready}, 32'd1);
    wq.push_back('{16'h0061, 8'hB1, -1});
    tick();
    wr_valid = 1'b0;
`endif
    repeat (8) tick();
    chk("drain_pending", {31'd0, wr_pending}, 32'd0);
    chk("drain_queue", wq.size(), 32'd0);

    // Reset mid-operation with writes buffered and reads in flight
    disp_addr = 16'h0010; exp_rd = 8'hA5; disp_req = 1'b1;
    do_write(16'h0040, 8'h99, -1);
`ifdef FB_WR_FIFO_EN
    do_write(16'h0041, 8'h98, -1);
`else
    wr_addr = 16'h0041; wr_data = 8'h98; wr_valid = 1'b1;
    tick();
`endif
    chk("pre_rst_pending", {31'd0, wr_pending}, 32'd1);
    do_reset(1'b1);
    repeat (6) tick();
    chk("rst_no_commit_40", {24'd0, mem[16'h0040]}, 32'd0);
    chk("rst_no_commit_41", {24'd0, mem[16'h0041]}, 32'd0);
    chk("rst_pending_clear", {31'd0, wr_pending}, 32'd0);

    // Stall counter saturation
    force dut.r_stall_cnt = 16'hFFFD;
    tick();
    release dut.r_stall_cnt;
    tick();
    chk("sat_preload", {16'd0, stall_cnt}, 32'hFFFD);
    disp_addr = 16'h0010; exp_rd = 8'hA5; disp_req = 1'b1;
    do_write(16'h0050, 8'h5A, -1);
    chk("sat_start", {16'd0, stall_cnt}, 32'hFFFD);
    tick();
    chk("sat_fffe", {16'd0, stall_cnt}, 32'hFFFE);
    repeat (4) tick();
    chk("sat_ffff", {16'd0, stall_cnt}, 32'hFFFF);
    disp_req = 1'b0;
    repeat (6) tick();
    chk("sat_commit", {24'd0, mem[16'h0050]}, 32'h5A);
    chk("end_rd_queue", rq.size(), 32'd0);
    chk("end_wr_queue", wq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, frame-buffer address width (256x256 pixels).
REQ-002 SHALL have parameter DATA_W, default 8, pixel width (RGB 3-3-2).
REQ-003 SHALL have ports, in order:
- clk  in  1  clock
- rst  in  1  reset
- disp_req  in  1  display pixel read request
- disp_addr  in  ADDR_W  display read address
- disp_data  out  DATA_W  display read data
- disp_valid  out  1  disp_data valid strobe
- wr_valid  in  1  writer request
- wr_addr  in  ADDR_W  writer address
- wr_data  in  DATA_W  writer pixel
- wr_ready  out  1  writer may transfer
- ram_en  out  1  RAM port enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, 1-cycle sync latency
- wr_pending  out  1  write buffer non-empty
- stall_cnt  out  16  cycles a pending write was blocked by display
REQ-004 SHALL use clock clk; reset rst, asynchronous, active-high.

Function
REQ-005 SHALL share one single-port frame-buffer RAM between display reads and writer writes; display has absolute priority, never stalled.
REQ-006 SHALL run FSM with states IDLE, RD, WR, re-evaluated every cycle: disp_req=1 -> RD; else wr_pending=1 -> WR; else IDLE.
REQ-007 SHALL register all ram_* outputs: RD drives ram_en=1, ram_we=0, ram_addr=disp_addr sampled the previous cycle; WR drives ram_en=1, ram_we=1, addr/data = buffer head; IDLE drives ram_en=0, ram_we=0.
REQ-008 SHALL give fixed read latency of 2: disp_req sampled at edge N -> ram_en at N+1 -> disp_valid=1 with disp_data=ram_rdata at N+2.
REQ-009 SHALL drive disp_data=0 whenever disp_valid=0.
REQ-010 SHALL accept a write when wr_valid&&wr_ready at a clock edge; wr_data/wr_addr held by writer until accepted.
REQ-011 SHALL commit buffered writes in acceptance order, one per WR cycle; buffer head popped on the edge WR is entered.
REQ-012 SHALL perform no read/write forwarding: display read of an address with a pending write returns old RAM contents.
REQ-013 SHALL increment stall_cnt each cycle wr_pending=1 and disp_req=1, saturating at 16'hFFFF (no wrap).
REQ-014 SHALL assert wr_pending combinationally from buffer occupancy > 0.

Reset
REQ-015 SHALL on rst force state IDLE, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, disp_valid=0, disp_data=0, stall_cnt=0, buffer emptied.
REQ-016 SHALL discard any buffered or in-flight write on rst mid-operation; a read in flight produces no disp_valid.
REQ-017 SHALL assert wr_ready in the first cycle after rst deasserts.

Configuration
REQ-018 SHALL, with FB_WR_FIFO_EN defined, buffer writes in a 4-entry FIFO: wr_ready = not full; simultaneous accept and pop in one cycle allowed, occupancy unchanged; accept when full never occurs.
REQ-019 SHALL, without FB_WR_FIFO_EN, use a single holding register: wr_ready = register empty; after pop, wr_ready reasserts the following cycle (no same-cycle refill).

Verification
REQ-020 Bench SHALL cover: disp_req pulse, disp_addr=16'h0010, RAM holds 8'hA5 there -> disp_valid=1, disp_data=8'hA5 exactly 2 cycles later.
REQ-021 Bench SHALL cover: disp_req=0, write (16'h0020, 8'h3C) -> ram_we=1, ram_addr=16'h0020, ram_wdata=8'h3C next cycle; readback returns 8'h3C.
REQ-022 Bench SHALL cover: disp_req held high 100 cycles with one write pending -> no ram_we during window, stall_cnt=100, write commits first cycle after disp_req drops.
REQ-023 Bench SHALL cover (FIFO build): 5 back-to-back writes while disp_req=1 -> wr_ready=0 after 4th; after release, commits in order 1..5.
REQ-024 Bench SHALL cover: rst asserted with 2 writes buffered -> all outputs per REQ-015 immediately; neither write reaches RAM; wr_ready=1 after release.
REQ-025 Bench SHALL cover: force stall_cnt near 16'hFFFE, 5 more stalled cycles -> stall_cnt holds 16'hFFFF.
